// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage <-> hazard scoreboard signal bundle
// master: decode side (drives ID fields and flush, sees stall/issue/halted and stats)
// slave : scoreboard side
// Stats signals and CNT_WIDTH exist only with HAZARD_SCOREBOARD_STATS_EN defined.
interface hazard_scoreboard_if #(
  parameter int REG_WIDTH = 5
`ifdef HAZARD_SCOREBOARD_STATS_EN
  , parameter int CNT_WIDTH = 32
`endif
);
  logic                 id_valid;
  logic [REG_WIDTH-1:0] id_rs1;
  logic                 id_rs1_used;
  logic [REG_WIDTH-1:0] id_rs2;
  logic                 id_rs2_used;
  logic [REG_WIDTH-1:0] id_rd;
  logic                 id_rd_wr;
  logic                 id_halt;
  logic                 flush;
  logic                 stall;
  logic                 issue;
  logic                 halted;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] hazard_events;
  logic [CNT_WIDTH-1:0] issued_instrs;
  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_rd_wr, id_halt, flush,
    input  stall, issue, halted, stall_cycles, hazard_events, issued_instrs
  );
  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_rd_wr, id_halt, flush,
    output stall, issue, halted, stall_cycles, hazard_events, issued_instrs
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_rd_wr, id_halt, flush,
    input  stall, issue, halted
  );
  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_rd_wr, id_halt, flush,
    output stall, issue, halted
  );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tracking, ID issue/stall and halt drain
// clock : pipeline clock
// rst   : asynchronous active-low reset
// sb    : hazard_scoreboard_if.slave (ID fields, flush in; stall/issue/halted, stats out)
// Macro HAZARD_SCOREBOARD_STATS_EN adds saturating stall/hazard/issue counters.
module hazard_scoreboard #(
  parameter int REG_WIDTH = 5
`ifdef HAZARD_SCOREBOARD_STATS_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input logic               clock,
  input logic               rst,
  hazard_scoreboard_if.slave sb
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t                        r_state;
  logic                          r_halted;
  logic [2:0]                    r_vld;
  // WB never hazards (write-then-read register file), so only EX/MEM keep rd
  logic [1:0][REG_WIDTH-1:0]     r_rd;
  logic                          w_run, w_hit1, w_hit2, w_stall, w_issue;
  assign w_run   = r_state == RUN;
  assign w_hit1  = sb.id_rs1_used & ((r_vld[0] & (sb.id_rs1 == r_rd[0])) | (r_vld[1] & (sb.id_rs1 == r_rd[1])));
  assign w_hit2  = sb.id_rs2_used & ((r_vld[0] & (sb.id_rs2 == r_rd[0])) | (r_vld[1] & (sb.id_rs2 == r_rd[1])));
  assign w_stall = sb.id_valid & (w_hit1 | w_hit2) & ~sb.flush & w_run;
  assign w_issue = sb.id_valid & ~w_stall & ~sb.flush & w_run;
  assign sb.stall  = w_stall;
  assign sb.issue  = w_issue;
  assign sb.halted = r_halted;
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
      r_vld    <= '0;
      r_rd     <= '0;
    end else begin
      r_vld <= {r_vld[1:0], w_issue & sb.id_rd_wr};
      r_rd  <= {r_rd[0], sb.id_rd};
      if (w_issue && sb.id_halt) r_state <= DRAIN;
      if (r_state == DRAIN && r_vld == '0) begin
        r_state  <= HALTED;
        r_halted <= 1'b1;
      end
    end
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic                 r_prev_stall;
  logic [CNT_WIDTH-1:0] r_stall_cycles, r_hazard_events, r_issued;
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      r_prev_stall    <= 1'b0;
      r_stall_cycles  <= '0;
      r_hazard_events <= '0;
      r_issued        <= '0;
    end else if (r_state != HALTED) begin
      r_prev_stall    <= w_stall;
      r_stall_cycles  <= r_stall_cycles + CNT_WIDTH'(w_stall && r_stall_cycles != '1);
      r_hazard_events <= r_hazard_events + CNT_WIDTH'(w_stall && !r_prev_stall && r_hazard_events != '1);
      r_issued        <= r_issued + CNT_WIDTH'(w_issue && r_issued != '1);
    end
  assign sb.stall_cycles  = r_stall_cycles;
  assign sb.hazard_events = r_hazard_events;
  assign sb.issued_instrs = r_issued;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of hazard_scoreboard issue/stall/halt/reset
module tb_hazard_scoreboard;
  logic clock = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  hazard_scoreboard_if bus();
  hazard_scoreboard dut (.clock(clock), .rst(rst), .sb(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] a, input logic au, input logic [4:0] b,
                     input logic bu, input logic [4:0] d, input logic dw, input logic h, input logic f);
    bus.id_valid    = v;
    bus.id_rs1      = a;
    bus.id_rs1_used = au;
    bus.id_rs2      = b;
    bus.id_rs2_used = bu;
    bus.id_rd       = d;
    bus.id_rd_wr    = dw;
    bus.id_halt     = h;
    bus.flush       = f;
  endtask
  task automatic do_reset;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b1;
  endtask
  initial begin
    // reset state and back-to-back dependency
    do_reset;
    drv(1, 1, 1, 2, 1, 3, 1, 0, 1); #1;
    chk("rst_issue_flush", bus.issue, 0);
    chk("rst_stall_flush", bus.stall, 0);
    drv(1, 1, 1, 2, 1, 3, 1, 0, 0); #1;
    chk("rst_halted", bus.halted, 0);
    chk("rst_stall", bus.stall, 0);
    chk("t1_c0_issue", bus.issue, 1);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    chk("rst_stall_cycles", bus.stall_cycles, 0);
    chk("rst_hazard_events", bus.hazard_events, 0);
    chk("rst_issued", bus.issued_instrs, 0);
`endif
    @(negedge clock); drv(1, 3, 1, 4, 1, 6, 1, 0, 0); #1;
    chk("t1_c1_stall", bus.stall, 1);
    chk("t1_c1_issue", bus.issue, 0);
    @(negedge clock); #1;
    chk("t1_c2_stall", bus.stall, 1);
    @(negedge clock); #1;
    chk("t1_c3_stall", bus.stall, 0);
    chk("t1_c3_issue", bus.issue, 1);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    chk("t1_stall_cycles", bus.stall_cycles, 2);
    chk("t1_hazard_events", bus.hazard_events, 1);
    chk("t1_issued", bus.issued_instrs, 1);
`endif
    // distance-2, distance-3 and register 0
    do_reset;
    drv(1, 1, 1, 2, 1, 5, 1, 0, 0); #1;
    chk("t2_c0_issue", bus.issue, 1);
    @(negedge clock); drv(1, 1, 1, 2, 1, 8, 1, 0, 0); #1;
    chk("t2_c1_stall", bus.stall, 0);
    chk("t2_c1_issue", bus.issue, 1);
    @(negedge clock); drv(1, 4, 1, 5, 1, 0, 1, 0, 0); #1;
    chk("t2_c2_stall", bus.stall, 1);
    @(negedge clock); #1;
    chk("t2_dist3_stall", bus.stall, 0);
    chk("t2_dist3_issue", bus.issue, 1);
    @(negedge clock); drv(1, 0, 1, 2, 0, 9, 1, 0, 0); #1;
    chk("t2_r0_stall", bus.stall, 1);
    // unused operand, then flush over hazard
    do_reset;
    drv(1, 1, 1, 2, 1, 7, 1, 0, 0); #1;
    chk("t3_c0_issue", bus.issue, 1);
    @(negedge clock); drv(1, 1, 1, 7, 0, 9, 1, 0, 0); #1;
    chk("t3_unused_stall", bus.stall, 0);
    chk("t3_unused_issue", bus.issue, 1);
    @(negedge clock); drv(1, 9, 1, 2, 0, 10, 1, 0, 1); #1;
    chk("t4_flush_stall", bus.stall, 0);
    chk("t4_flush_issue", bus.issue, 0);
    @(negedge clock); drv(1, 10, 1, 2, 0, 11, 1, 0, 0); #1;
    chk("t4_bubble_stall", bus.stall, 0);
    chk("t4_bubble_issue", bus.issue, 1);
    @(negedge clock); drv(1, 1, 0, 2, 0, 0, 0, 1, 1); #1;
    chk("t4_halt_flush_issue", bus.issue, 0);
    @(negedge clock); drv(1, 1, 0, 2, 0, 12, 1, 0, 0); #1;
    chk("t4_after_halt_flush_issue", bus.issue, 1);
    @(negedge clock); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clock);
    #1;
    chk("t4_no_halt", bus.halted, 0);
    // halt drain: writers at 7..9, halt at 10
    do_reset;
    drv(1, 1, 1, 2, 1, 11, 1, 0, 0); #1;
    chk("t5_w1_issue", bus.issue, 1);
    @(negedge clock); drv(1, 1, 1, 2, 1, 12, 1, 0, 0);
    @(negedge clock); drv(1, 1, 1, 2, 1, 13, 1, 0, 0);
    @(negedge clock); drv(1, 1, 0, 2, 0, 0, 0, 1, 0); #1;
    chk("t5_c10_halt_issue", bus.issue, 1);
    @(negedge clock); drv(1, 13, 1, 2, 0, 14, 1, 0, 0); #1;
    chk("t5_c11_issue", bus.issue, 0);
    chk("t5_c11_stall", bus.stall, 0);
    chk("t5_c11_halted", bus.halted, 0);
    @(negedge clock); #1;
    chk("t5_c12_halted", bus.halted, 0);
    @(negedge clock); #1;
    chk("t5_c13_halted", bus.halted, 0);
    @(negedge clock); #1;
    chk("t5_c14_halted", bus.halted, 1);
    chk("t5_c14_issue", bus.issue, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    chk("t5_c14_issued", bus.issued_instrs, 4);
`endif
    repeat (2) @(negedge clock);
    #1;
    chk("t5_c16_halted", bus.halted, 1);
    chk("t5_c16_issue", bus.issue, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    chk("t5_c16_issued", bus.issued_instrs, 4);
    chk("t5_c16_stall_cycles", bus.stall_cycles, 0);
`endif
    // asynchronous reset in the middle of a stall
    do_reset;
    drv(1, 1, 1, 2, 1, 3, 1, 0, 0);
    @(negedge clock); drv(1, 3, 1, 2, 0, 4, 1, 0, 0); #1;
    chk("t6_pre_stall", bus.stall, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_stall", bus.stall, 0);
    chk("t6_async_issue", bus.issue, 1);
    chk("t6_async_halted", bus.halted, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    chk("t6_async_issued", bus.issued_instrs, 0);
    chk("t6_async_stall_cycles", bus.stall_cycles, 0);
`endif
    @(negedge clock); rst = 1'b1; #1;
    chk("t6_post_stall", bus.stall, 0);
    chk("t6_post_issue", bus.issue, 1);
    @(negedge clock); drv(1, 4, 1, 2, 0, 5, 1, 0, 0); #1;
    chk("t6_new_hazard_stall", bus.stall, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
